// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the issue stage and the integer ALU.
package riscv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam int FUNC7_ALT = 5;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [4:0]  rd;
      logic        illegal;
   } issue_bundle_t;

   // Only shift-immediates carry a meaningful func7; others must not select SUB.
   function automatic logic is_shift(input logic [2:0] f3);
      return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two combinational read ports, one write port,
// x0 hardwired to zero, and same-cycle write-to-read bypass.
module regfile_2r1w (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  raddr1_i,
   output logic [31:0] rdata1_o,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata2_o,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i
);

   logic [31:0] regs_q [32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata1_o = regs_q[raddr1_i];
      if (raddr1_i == 5'd0)                      rdata1_o = '0;
      else if (we_i && (waddr_i == raddr1_i))    rdata1_o = wdata_i;
   end

   always_comb begin
      rdata2_o = regs_q[raddr2_i];
      if (raddr2_i == 5'd0)                      rdata2_o = '0;
      else if (we_i && (waddr_i == raddr2_i))    rdata2_o = wdata_i;
   end

endmodule

// File: rtl/issue_stage.sv
// RV32I decode/issue stage: operand read, scoreboard hazard stall and a
// registered operand bundle toward the integer ALU.
module issue_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [2:0]  out_func3,
   output logic [6:0]  out_func7,
   output logic [4:0]  out_rd,
   output logic        out_illegal,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data
);

   logic [6:0]    opc;
   logic [4:0]    rs1, rs2, rd_raw;
   logic [2:0]    f3_raw;
   logic [31:0]   rdata1, rdata2;
   logic          use_rs1, use_rs2;
   issue_bundle_t dec;

   logic          valid_q, valid_d;
   issue_bundle_t bundle_q, bundle_d;
   logic [31:0]   sb_q, sb_d;

   logic          hazard, accept;

   assign opc    = in_instr[6:0];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign rd_raw = in_instr[11:7];
   assign f3_raw = in_instr[14:12];

   regfile_2r1w u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .raddr1_i (rs1),
      .rdata1_o (rdata1),
      .raddr2_i (rs2),
      .rdata2_o (rdata2),
      .we_i     (wb_en),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data)
   );

   always_comb begin
      dec     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      unique case (opc)
         OPC_OP: begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            dec.a     = rdata1;
            dec.b     = rdata2;
            dec.func3 = f3_raw;
            dec.func7 = in_instr[31:25];
            dec.rd    = rd_raw;
         end
         OPC_OP_IMM: begin
            use_rs1   = 1'b1;
            dec.a     = rdata1;
            dec.b     = {{20{in_instr[31]}}, in_instr[31:20]};
            dec.func3 = f3_raw;
            dec.func7 = is_shift(f3_raw) ? in_instr[31:25] : 7'd0;
            dec.rd    = rd_raw;
         end
         OPC_LUI: begin
            dec.b  = {in_instr[31:12], 12'd0};
            dec.rd = rd_raw;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   // A pending register stops blocking in the very cycle its writeback arrives.
   function automatic logic blocked(input logic [4:0] r);
      return (r != 5'd0) && sb_q[r] && !(wb_en && (wb_rd == r));
   endfunction

   assign hazard   = (use_rs1 && blocked(rs1)) || (use_rs2 && blocked(rs2)) ||
                     (!dec.illegal && blocked(dec.rd));
   assign in_ready = (!valid_q || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   always_comb begin
      sb_d = sb_q;
      if (wb_en) sb_d[wb_rd] = 1'b0;
      if (accept && !dec.illegal && (dec.rd != 5'd0)) sb_d[dec.rd] = 1'b1;
      sb_d[0] = 1'b0;
   end

   always_comb begin
      valid_d  = valid_q;
      bundle_d = bundle_q;
      if (accept) begin
         valid_d  = 1'b1;
         bundle_d = dec;
      end else if (out_ready) begin
         valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
         sb_q     <= '0;
      end else begin
         valid_q  <= valid_d;
         bundle_q <= bundle_d;
         sb_q     <= sb_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_a       = bundle_q.a;
   assign out_b       = bundle_q.b;
   assign out_func3   = bundle_q.func3;
   assign out_func7   = bundle_q.func7;
   assign out_rd      = bundle_q.rd;
   assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_issue_stage.sv
// Directed plus randomized bench for issue_stage against an architectural
// model (register array, pending set, single output slot).
module tb_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a, out_b;
   logic [2:0]  out_func3;
   logic [6:0]  out_func7;
   logic [4:0]  out_rd;
   logic        out_illegal;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;

   issue_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_func3(out_func3), .out_func7(out_func7),
      .out_rd(out_rd), .out_illegal(out_illegal),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   logic [31:0] m_regs [32];
   bit   [31:0] m_pend;
   logic        m_valid;
   logic [31:0] m_a, m_b;
   logic [2:0]  m_f3;
   logic [6:0]  m_f7;
   logic [4:0]  m_rd;
   logic        m_ill;
   logic        obs_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pend = '0; m_valid = 1'b0;
      m_a = '0; m_b = '0; m_f3 = '0; m_f7 = '0; m_rd = '0; m_ill = 1'b0;
   endtask

   function automatic logic [31:0] rd_ref(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_en && wb_rd == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic logic busy(input logic [4:0] r);
      return (r != 5'd0) && m_pend[r] && !(wb_en && wb_rd == r);
   endfunction

   // Architectural meaning of one instruction word.
   task automatic ref_decode(input logic [31:0] i, output logic [31:0] a, output logic [31:0] b,
                             output logic [2:0] f3, output logic [6:0] f7, output logic [4:0] rd,
                             output logic ill, output logic haz);
      logic [4:0] s1, s2;
      s1 = i[19:15]; s2 = i[24:20];
      a = 0; b = 0; f3 = 0; f7 = 0; rd = 0; ill = 0; haz = 0;
      case (i[6:0])
         7'b0110011: begin
            a = rd_ref(s1); b = rd_ref(s2); f3 = i[14:12]; f7 = i[31:25]; rd = i[11:7];
            haz = busy(s1) || busy(s2) || busy(rd);
         end
         7'b0010011: begin
            a = rd_ref(s1); b = {{20{i[31]}}, i[31:20]}; f3 = i[14:12];
            f7 = (f3 == 3'd1 || f3 == 3'd5) ? i[31:25] : 7'd0; rd = i[11:7];
            haz = busy(s1) || busy(rd);
         end
         7'b0110111: begin
            b = {i[31:12], 12'd0}; rd = i[11:7];
            haz = busy(rd);
         end
         default: ill = 1'b1;
      endcase
   endtask

   task automatic step(input logic v, input logic [31:0] instr, input logic ordy,
                       input logic wen, input logic [4:0] wrd, input logic [31:0] wdat);
      logic [31:0] a, b; logic [2:0] f3; logic [6:0] f7; logic [4:0] rd;
      logic ill, haz, exp_ready, acc;
      in_valid = v; in_instr = instr; out_ready = ordy;
      wb_en = wen; wb_rd = wrd; wb_data = wdat;
      #1;
      ref_decode(instr, a, b, f3, f7, rd, ill, haz);
      exp_ready = (!m_valid || ordy) && !haz;
      acc = v && exp_ready;
      obs_ready = in_ready;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      @(posedge clk);
      if (acc) begin
         m_valid = 1'b1; m_a = a; m_b = b; m_f3 = f3; m_f7 = f7; m_rd = rd; m_ill = ill;
      end else if (ordy) m_valid = 1'b0;
      if (wen && wrd != 0) m_regs[wrd] = wdat;
      if (wen) m_pend[wrd] = 1'b0;
      if (acc && !ill && rd != 0) m_pend[rd] = 1'b1;
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out_a", out_a, m_a);
      chk("out_b", out_b, m_b);
      chk("out_func3", {29'd0, out_func3}, {29'd0, m_f3});
      chk("out_func7", {25'd0, out_func7}, {25'd0, m_f7});
      chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
      @(negedge clk);
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, s2, s1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  f7;
      r = $urandom();
      f7 = r[31] ? 7'h20 : 7'h00;
      case ($urandom_range(0, 3))
         0:       return enc_r(f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                               r[14:12], 5'($urandom_range(0, 7)));
         1:       return {r[31:20], 5'($urandom_range(0, 7)), r[14:12],
                          5'($urandom_range(0, 7)), 7'b0010011};
         2:       return {r[31:12], 5'($urandom_range(0, 7)), 7'b0110111};
         default: return {r[31:7], 7'b1110011};
      endcase
   endfunction

   logic [31:0] snap_a, snap_b;
   logic [4:0]  snap_rd;

   initial begin
      model_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3; out_ready = 1'b1;
      wb_en = 1'b0; wb_rd = '0; wb_data = '0;
      #3;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      step(1, 32'h002081B3, 1, 0, 0, 0);
      chk("add_zero_a", out_a, 32'd0);
      chk("add_zero_b", out_b, 32'd0);
      step(0, 0, 1, 1, 5'd1, 32'd5);
      step(0, 0, 1, 1, 5'd2, 32'd3);
      step(0, 0, 1, 1, 5'd3, 32'd0);

      step(1, 32'h002081B3, 1, 0, 0, 0);
      chk("add_a", out_a, 32'd5);
      chk("add_b", out_b, 32'd3);
      chk("add_rd", {27'd0, out_rd}, 32'd3);
      step(1, 32'hFFF08213, 1, 0, 0, 0);
      chk("addi_b", out_b, 32'hFFFFFFFF);
      chk("addi_f7", {25'd0, out_func7}, 32'd0);
      step(1, 32'h4030D293, 1, 0, 0, 0);
      chk("srai_f7", {25'd0, out_func7}, 32'h20);
      chk("srai_sh", {27'd0, out_b[4:0]}, 32'd3);

      step(1, 32'h40118333, 1, 0, 0, 0);
      chk("raw_stall0", {31'd0, obs_ready}, 32'd0);
      step(1, 32'h40118333, 1, 0, 0, 0);
      chk("raw_stall1", {31'd0, obs_ready}, 32'd0);
      step(1, 32'h40118333, 1, 1, 5'd3, 32'd8);
      chk("raw_release", {31'd0, obs_ready}, 32'd1);
      chk("sub_a", out_a, 32'd8);
      chk("sub_b", out_b, 32'd5);
      chk("sub_f7", {25'd0, out_func7}, 32'h20);

      snap_a = out_a; snap_b = out_b; snap_rd = out_rd;
      for (int k = 0; k < 3; k++) begin
         step(1, enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd7), 0, 0, 0, 0);
         chk("bp_ready", {31'd0, obs_ready}, 32'd0);
         chk("bp_a", out_a, snap_a);
         chk("bp_b", out_b, snap_b);
         chk("bp_rd", {27'd0, out_rd}, {27'd0, snap_rd});
      end
      step(0, 0, 1, 0, 0, 0);
      chk("bp_drain", {31'd0, out_valid}, 32'd0);
      step(0, 0, 1, 1, 5'd4, 32'd11);
      step(0, 0, 1, 1, 5'd5, 32'd12);
      step(0, 0, 1, 1, 5'd6, 32'd13);

      step(1, 32'h00000073, 1, 0, 0, 0);
      chk("ill_flag", {31'd0, out_illegal}, 32'd1);
      chk("ill_rd", {27'd0, out_rd}, 32'd0);
      step(0, 0, 1, 1, 5'd0, 32'hDEADBEEF);
      step(1, enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd8), 1, 0, 0, 0);
      chk("x0_a", out_a, 32'd0);
      chk("x0_b", out_b, 32'd0);

      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
      end

      rst_n = 1'b0; in_valid = 1'b1;
      #1;
      model_reset();
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_a", out_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 100; n++) begin
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_stage.md
# issue_stage

Decode/issue stage sitting directly upstream of the integer ALU. Accepts 32-bit RV32I instructions from fetch over a valid/ready handshake and reads operands from an internal 2R1W register file. Tracks in-flight destinations with a scoreboard and stalls on hazards. Delivers registered ALU operands (a, b, func3, func7) plus rd to execute, and takes results back over a writeback port.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute consumes bundle
- out_a  out  32  ALU operand a
- out_b  out  32  ALU operand b
- out_func3  out  3  ALU func3
- out_func7  out  7  ALU func7 (bit 5 selects SUB/SRA)
- out_rd  out  5  destination register
- out_illegal  out  1  unsupported opcode
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback register
- wb_data  in  32  writeback value

## Operation
- Decode by opcode instr[6:0]:
  - OP (0110011): a=rs1, b=rs2, func3=instr[14:12], func7=instr[31:25].
  - OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20]. func7=instr[31:25] only when func3 is 001 or 101, else 0, so ADDI never subtracts.
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, func3=0, func7=0.
  - Other opcodes: out_illegal=1, rd=0, a=b=func3=func7=0.
- rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7]. Sources used: OP uses rs1 and rs2; OP-IMM uses rs1; LUI and illegal use none.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - When wb_en=1 and wb_rd equals a source register (nonzero), that read returns wb_data in the same cycle (bypass).
- Scoreboard: 32 pending bits, bit 0 always 0.
  - Set for rd (nonzero, legal instruction) on accept.
  - Cleared on wb_en for wb_rd.
  - Set and clear of the same bit in one cycle: set wins.
- hazard=1 when either condition holds:
  - a used source is pending and not being written back this cycle;
  - rd is pending and not being written back this cycle (WAW).
- in_ready = (!out_valid || out_ready) && !hazard. Accept = in_valid && in_ready.
- Output register:
  - On accept, load all out_* fields and set out_valid=1.
  - Else if out_ready=1, out_valid=0.
  - While out_valid && !out_ready, all out_* fields hold stable.

## Timing
- Reset values: out_valid=0, all out_* fields 0, scoreboard 0, every register 0. in_ready=1 while in reset.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction/cycle absent hazards.
- A writeback in cycle N releases a dependent instruction in cycle N; the bundle in cycle N+1 carries wb_data.
- in_ready is combinational from in_instr, out_valid, out_ready, and wb_en/wb_rd. There is no path from in_valid to in_ready.
- in_valid may drop or in_instr may change while in_ready=0; the stage samples only on accept.
- Reset asserted mid-operation clears all state immediately, including an unconsumed bundle and pending bits.

## Structure
- Shared package riscv_pkg:
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI;
  - FUNC7_ALT bit index (5);
  - func3 codes shared with the ALU.
- One sub-module, regfile_2r1w: async-reset 32x32 register file with two combinational read ports, one write port, x0 forced to zero, and write-to-read bypass.
- Decode, scoreboard, and the output register live in issue_stage.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0 and in_ready=1. After release, issue ADD x3,x1,x2 (0x002081B3) → out_a=0, out_b=0.
- Write x1=5 and x2=3 via wb, then issue 0x002081B3 → next cycle out_a=5, out_b=3, func3=0, func7=0, rd=3.
- Immediate forms:
  - ADDI x4,x1,-1 (0xFFF08213) → out_b=0xFFFFFFFF, func7=0.
  - SRAI x5,x1,3 (0x4030D293) → func7=0x20, out_b[4:0]=3.
- RAW hazard: ADD x3 then SUB x6,x3,x1 (0x40118333) → in_ready=0 until wb_en=1, wb_rd=3, wb_data=8. That cycle in_ready=1; next cycle out_a=8, out_b=5, func7=0x20.
- Backpressure: out_ready=0 for 3 cycles with a valid bundle → out_* stable, in_ready=0, bundle delivered once, pending bit set once.
- Illegal and x0 handling:
  - 0x00000073 → out_illegal=1, rd=0, no pending bit set.
  - wb to x0 with data 0xDEADBEEF, then read x0 → 0.
